jt6295_rom_arb: RTL
===================

// Module: jt6295_rom_arb
// PURPOSE
//  Parametrised ROM-access arbiter for the ADPCM sample engine. Generalises the fixed 4-voice fetch path
//  to CH voices: each voice posts a byte request, a round-robin pick grants one, and the arbiter drives
//  the shared rom_addr and waits on rom_ok. It returns rom_data with a one-cycle ack to the winning voice.
//  Sits between the voice sequencers and the external ROM/SDRAM port.
// PARAMETERS
//  CH  4    number of requesting voices (1..16)
//  AW  18   ROM byte-address width
//  DW  8    ROM data width
//  TO  255  watchdog limit in clk cycles (used only with JT6295_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1      system clock; single clock domain
//  rst       in   1      synchronous, active-low reset (0 = reset), sampled on posedge clk
//  req       in   CH     per-voice request level; held until that voice's ack
//  addr      in   CH*AW  per-voice byte address; voice i at [i*AW +: AW]
//  ack       out  CH     one-cycle pulse: dout valid for that voice
//  dout      out  DW     data of last completed access; held until next ack
//  busy      out  1      high while an access is outstanding (state WAIT)
//  rom_addr  out  AW     address to ROM; stable for the whole access
//  rom_data  in   DW     ROM data
//  rom_ok    in   1      ROM data valid for current rom_addr
//  err       out  1      sticky timeout flag (tied 0 without JT6295_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: ack=0, dout=0, busy=0, rom_addr=0, err=0, rr pointer=0, state=IDLE. Reset mid-access drops it; no ack.
//  - Runs on every clk (no cen gating) so ROM latency is not stretched by the audio clock enable.
//  - IDLE: eligible = req & ~ack (masks the voice acked last cycle, which has not yet dropped req).
//    If eligible!=0: g = first set bit at or after ptr, wrapping modulo CH. Registered updates:
//    sel<=g, rom_addr<=addr[g], settle<=1, busy<=1, go WAIT.
//  - WAIT: first cycle (settle=1) ignores rom_ok, which is stale for the previous address; then clears settle.
//    When settle=0 and rom_ok=1:
//    dout<=rom_data, ack[sel]<=req[sel], ptr<=(sel+1)%CH, busy<=0, go IDLE.
//  - Min latency: req sampled at edge n -> rom_addr at n -> ack high after edge n+2 if rom_ok is already 1.
//  - If req[sel] drops during WAIT, the access completes, dout updates, and no ack is issued.
//  - addr changes during WAIT are ignored; rom_addr is latched at grant.
//  - ack is one-hot or zero and is never high in two consecutive cycles for the same voice.
//  - CH=1: ptr stays 0, and the pick degenerates to req[0]&~ack[0]; the pointer width is max(1,$clog2(CH)).
// CONFIGURATION
//  JT6295_ARB_TIMEOUT_EN defined: a cycle counter runs in WAIT. When it reaches TO with no rom_ok,
//    complete as if rom_ok with dout<=0, set err<=1 (sticky until reset), and advance ptr.
//  Undefined: no counter. WAIT blocks indefinitely until rom_ok, and err is constant 0.
// STRUCTURE
//  - jt6295_pkg: state encoding (IDLE/WAIT) and defaults for AW/DW.
//  - Sub-module jt6295_rr_pick(CH): combinational round-robin picker (eligible, ptr -> g, any).
//    Instantiated once; all registers stay in jt6295_rom_arb.
// TESTING
//  1. CH=4. req=4'b0001, addr0=18'h00100, ROM returns rom_ok one cycle after the address settles ->
//     rom_addr=00100, ack=0001 exactly 2 cycles after req sampled, dout=rom[00100].
//  2. req=4'b1111 held continuously -> grants in order 0,1,2,3,0. No voice is acked twice in a row.
//     busy drops for exactly one cycle between accesses.
//  3. rom_ok held 1 constantly across an address change -> stale rom_ok is ignored in the settle cycle.
//     dout equals the data for the new address, never the old one.
//  4. Drop req[2] while in WAIT with rom_ok delayed 5 cycles -> no ack[2]. dout updates.
//     The next grant goes to voice 3.
//  5. Pull rst low mid-WAIT -> next cycle ack=0, busy=0, rom_addr=0. Voice 0 wins the first grant after release.
//  6. With JT6295_ARB_TIMEOUT_EN, TO=8, rom_ok=0 forever -> ack after 8 WAIT cycles, dout=0, err=1 and stays 1.
//     Without the macro, busy stays 1 and no ack is issued.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared types and defaults for the jt6295 ROM-access arbiter.
// Optional feature macro: JT6295_ARB_TIMEOUT_EN (watchdog on the ROM wait).
package jt6295_pkg;

  // Arbiter state: waiting for a request, or holding an access open on the ROM port
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int unsigned DEF_CH = 4;
  localparam int unsigned DEF_AW = 18;
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_TO = 255;

  // Voice-index width; a single voice still needs one bit to hold index 0
  function automatic int unsigned ptr_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/jt6295_rr_pick.sv
// Combinational round-robin picker: first eligible voice at or after ptr, wrapping modulo CH.
module jt6295_rr_pick
  import jt6295_pkg::*;
#(
  parameter  int unsigned CH = DEF_CH,
  localparam int unsigned PW = ptr_w(CH)
) (
  input  logic [CH-1:0] eligible,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] g_c,
  output logic          any_c
);

  logic [CH-1:0] rot;

  // Scan CH positions starting at ptr; the first hit wins
  always_comb begin
    g_c   = '0;
    any_c = 1'b0;
    rot   = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      int unsigned idx;
      idx = 32'(ptr) + i;
      if (idx >= CH) idx = idx - CH;
      rot = eligible >> idx;
      if (!any_c && rot[0]) begin
        any_c = 1'b1;
        g_c   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/jt6295_rom_arb.sv
// Round-robin ROM-access arbiter for CH ADPCM voices sharing one ROM/SDRAM byte port.
// Optional feature macro: JT6295_ARB_TIMEOUT_EN adds a TO-cycle watchdog and sticky err.
module jt6295_rom_arb
  import jt6295_pkg::*;
#(
  parameter  int unsigned CH = DEF_CH,
  parameter  int unsigned AW = DEF_AW,
  parameter  int unsigned DW = DEF_DW,
  parameter  int unsigned TO = DEF_TO,
  localparam int unsigned PW = ptr_w(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    req,
  input  logic [CH*AW-1:0] addr,
  output logic [CH-1:0]    ack,
  output logic [DW-1:0]    dout,
  output logic             busy,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  input  logic             rom_ok,
  output logic             err
);

  // Reject unsupported configurations at elaboration
  if (CH < 1 || CH > 16 || TO < 1) begin : g_bad_cfg
    $error("jt6295_rom_arb: CH must be 1..16 and TO at least 1");
  end

  state_t         state_q, state_d;
  logic [PW-1:0]  sel_q, sel_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [AW-1:0]  rom_addr_q, rom_addr_d;
  logic           settle_q, settle_d;
  logic           busy_q, busy_d;
  logic [CH-1:0]  ack_q, ack_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           err_q, err_d;
  logic           done;

`ifdef JT6295_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
`endif

  logic [AW-1:0]  addr_arr [CH];
  logic [CH-1:0]  eligible;
  logic [PW-1:0]  g_c;
  logic           any_c;

  // Unpack the flat per-voice address bus
  for (genvar i = 0; i < CH; i++) begin : g_addr
    assign addr_arr[i] = addr[i*AW +: AW];
  end

  // A voice acked last cycle still shows req high; keep it out of this pick
  assign eligible = req & ~ack_q;

  jt6295_rr_pick #(
    .CH (CH)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .g_c      (g_c),
    .any_c    (any_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    settle_d   = settle_q;
    busy_d     = busy_q;
    ack_d      = '0;
    dout_d     = dout_q;
    err_d      = err_q;
    done       = 1'b0;
`ifdef JT6295_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          sel_d      = g_c;
          rom_addr_d = addr_arr[g_c];
          settle_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_WAIT;
`ifdef JT6295_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_WAIT: begin
        // rom_ok in the settle cycle still refers to the previous address
        settle_d = 1'b0;
        if (!settle_q && rom_ok) begin
          dout_d = rom_data;
          done   = 1'b1;
        end
`ifdef JT6295_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TO - 1)) begin
          dout_d = '0;
          err_d  = 1'b1;
          done   = 1'b1;
        end
        cnt_d = cnt_q + CW'(1);
`endif
        if (done) begin
          // A voice that withdrew its request mid-access gets no ack
          ack_d[sel_q] = req[sel_q];
          ptr_d        = (32'(sel_q) == CH - 1) ? '0 : sel_q + PW'(1);
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      settle_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
`ifdef JT6295_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
`ifdef JT6295_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign rom_addr = rom_addr_q;
  assign err      = err_q;

endmodule
